// File: rtl/alu_pkg.sv
// Shared constants for the accumulator ALU pipeline: opcode and Y-select encodings.
package alu_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_ADC = 3'd6,
      OP_SHL = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      SEL_B   = 2'd0,
      SEL_D   = 2'd1,
      SEL_E   = 2'd2,
      SEL_ACC = 2'd3
   } sel_e;

endpackage

// File: rtl/alu_acc_pipe_if.sv
// Operand/result bundle for alu_acc_pipe: input handshake, operands, output handshake.
interface alu_acc_pipe_if #(parameter int unsigned WIDTH = 3);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b, c, d, e;
   logic             sel_1;
   logic [1:0]       sel_2;
   logic [OP_W-1:0]  opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             carry_out;
   logic [WIDTH-1:0] acc;

   modport master (
      output in_valid, a, b, c, d, e, sel_1, sel_2, opcode, out_ready,
      input  in_ready, out_valid, out, carry_out, acc
   );

   modport slave (
      input  in_valid, a, b, c, d, e, sel_1, sel_2, opcode, out_ready,
      output in_ready, out_valid, out, carry_out, acc
   );

endinterface

// File: rtl/alu_core.sv
// Combinational 8-op ALU. Define ALU_ACC_PIPE_SAT_EN to saturate ADD/ADC/SUB on overflow/borrow.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             carry_in,
   input  logic [OP_W-1:0]  opcode,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0] wide;

   always_comb begin
      wide   = '0;
      result = '0;
      carry  = 1'b0;
      case (op_e'(opcode))
         OP_ADD: begin
            wide   = {1'b0, x} + {1'b0, y};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
`ifdef ALU_ACC_PIPE_SAT_EN
            if (carry) result = '1;
`endif
         end
         OP_SUB: begin
            // Borrow appears as bit WIDTH of the extended difference
            wide   = {1'b0, x} - {1'b0, y};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
`ifdef ALU_ACC_PIPE_SAT_EN
            if (carry) result = '0;
`endif
         end
         OP_AND: result = x & y;
         OP_OR:  result = x | y;
         OP_XOR: result = x ^ y;
         OP_NOT: result = ~x;
         OP_ADC: begin
            wide   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, carry_in};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
`ifdef ALU_ACC_PIPE_SAT_EN
            if (carry) result = '1;
`endif
         end
         OP_SHL: begin
            wide   = {x, 1'b0};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_acc_pipe.sv
// Two-stage elastic ALU pipeline with accumulator operand and registered carry flag.
// Optional saturation via ALU_ACC_PIPE_SAT_EN (implemented in alu_core).
module alu_acc_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_acc_pipe_if.slave  bus
);

   if (WIDTH < 2) begin : g_width_check
      $error("alu_acc_pipe: WIDTH must be at least 2");
   end

   logic             s1_valid;
   logic [WIDTH-1:0] s1_x;
   logic [WIDTH-1:0] s1_y_raw;
   sel_e             s1_sel;
   logic [OP_W-1:0]  s1_op;

   logic             s2_valid;
   logic [WIDTH-1:0] out_q;
   logic             carry_q;
   logic [WIDTH-1:0] acc_q;
   logic             flag_q;

   logic             s2_advance;
   logic             in_ready;
   logic [WIDTH-1:0] x_mux;
   logic [WIDTH-1:0] y_raw_mux;
   logic [WIDTH-1:0] y_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   assign s2_advance = !s2_valid || bus.out_ready;
   assign in_ready   = !s1_valid || s2_advance;

   always_comb begin
      x_mux     = bus.sel_1 ? bus.c : bus.a;
      y_raw_mux = bus.b;
      case (sel_e'(bus.sel_2))
         SEL_D:   y_raw_mux = bus.d;
         SEL_E:   y_raw_mux = bus.e;
         default: y_raw_mux = bus.b;
      endcase
   end

   // Accumulator is chosen at compute time so a dependent op directly behind
   // its producer sees the freshly written value without a bubble.
   assign y_op = (s1_sel == SEL_ACC) ? acc_q : s1_y_raw;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .x        (s1_x),
      .y        (y_op),
      .carry_in (flag_q),
      .opcode   (s1_op),
      .result   (alu_result),
      .carry    (alu_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y_raw <= '0;
         s1_sel   <= SEL_B;
         s1_op    <= '0;
      end else if (in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_x     <= x_mux;
            s1_y_raw <= y_raw_mux;
            s1_sel   <= sel_e'(bus.sel_2);
            s1_op    <= bus.opcode;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_q    <= '0;
         carry_q  <= 1'b0;
         acc_q    <= '0;
         flag_q   <= 1'b0;
      end else if (s2_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_q   <= alu_result;
            carry_q <= alu_carry;
            acc_q   <= alu_result;
            flag_q  <= alu_carry;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid;
   assign bus.out       = out_q;
   assign bus.carry_out = carry_q;
   assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_acc_pipe.sv
// Directed self-checking bench for alu_acc_pipe (WIDTH=3); honours ALU_ACC_PIPE_SAT_EN.
module tb_alu_acc_pipe;
   import alu_pkg::*;

   localparam int unsigned W = 3;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   alu_acc_pipe_if #(.WIDTH(W)) bus ();

   alu_acc_pipe #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] e,
                        input logic s1, input logic [1:0] s2, input logic [2:0] op);
      bus.in_valid = v;
      bus.a = a; bus.b = b; bus.c = c; bus.d = d; bus.e = e;
      bus.sel_1 = s1; bus.sel_2 = s2; bus.opcode = op;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 2'd0, 3'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 2'd0, 3'd0);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 3'd0 ||
          bus.carry_out !== 1'b0 || bus.acc !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: out_valid=%b in_ready=%b out=%0d carry=%b acc=%0d, required 0 1 0 0 0",
                  bus.out_valid, bus.in_ready, bus.out, bus.carry_out, bus.acc);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      @(negedge clk);
      drive(1'b1, 3'd2, 3'd3, '0, '0, '0, 1'b0, 2'd0, OP_ADD);
      @(negedge clk);
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 2'd0, 3'd0);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_latency1: out_valid=%b, required 0", bus.out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== 3'd5 || bus.carry_out !== 1'b0 || bus.acc !== 3'd5) begin
         n_fail++;
         $display("FAIL add_result: valid=%b out=%0d carry=%b acc=%0d, required 1 5 0 5",
                  bus.out_valid, bus.out, bus.carry_out, bus.acc);
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_drain: out_valid=%b, required 0", bus.out_valid);
      end
   endtask

   task automatic test_sub_adc();
      logic [W-1:0] exp_sub;
`ifdef ALU_ACC_PIPE_SAT_EN
      exp_sub = 3'd0;
`else
      exp_sub = 3'd7;
`endif
      @(negedge clk);
      drive(1'b1, 3'd2, 3'd3, '0, '0, '0, 1'b0, 2'd0, OP_SUB);
      @(negedge clk);
      drive(1'b1, 3'd2, 3'd3, '0, '0, '0, 1'b0, 2'd0, OP_ADC);
      @(negedge clk);
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 2'd0, 3'd0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp_sub || bus.carry_out !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_borrow: valid=%b out=%0d carry=%b, required 1 %0d 1",
                  bus.out_valid, bus.out, bus.carry_out, exp_sub);
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== 3'd6 || bus.carry_out !== 1'b0 || bus.acc !== 3'd6) begin
         n_fail++;
         $display("FAIL adc_with_flag: valid=%b out=%0d carry=%b acc=%0d, required 1 6 0 6",
                  bus.out_valid, bus.out, bus.carry_out, bus.acc);
      end
   endtask

   task automatic test_back_to_back_acc();
      logic [W-1:0] exp_out [3] = '{3'd2, 3'd4, 3'd6};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== exp_out[i-2] || bus.acc !== exp_out[i-2]) begin
               n_fail++;
               $display("FAIL acc_chain[%0d]: valid=%b out=%0d acc=%0d, required 1 %0d %0d",
                        i-2, bus.out_valid, bus.out, bus.acc, exp_out[i-2], exp_out[i-2]);
            end
         end
         if (i < 3) drive(1'b1, 3'd2, 3'd7, '0, '0, '0, 1'b0, SEL_ACC, OP_ADD);
         else       drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 2'd0, 3'd0);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] exp_ovf;
`ifdef ALU_ACC_PIPE_SAT_EN
      exp_ovf = 3'd7;
`else
      exp_ovf = 3'd3;
`endif
      @(negedge clk);
      drive(1'b1, 3'd5, 3'd6, '0, '0, '0, 1'b0, 2'd0, OP_ADD);
      @(negedge clk);
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 2'd0, 3'd0);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp_ovf || bus.carry_out !== 1'b1 || bus.acc !== exp_ovf) begin
         n_fail++;
         $display("FAIL add_overflow: valid=%b out=%0d carry=%b acc=%0d, required 1 %0d 1 %0d",
                  bus.out_valid, bus.out, bus.carry_out, bus.acc, exp_ovf, exp_ovf);
      end
   endtask

   task automatic test_ops_and_muxes();
      logic [W-1:0] ta [6] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd5, 3'd3};
      logic [W-1:0] tb [6] = '{3'd3, 3'd0, 3'd1, 3'd7, 3'd0, 3'd0};
      logic [W-1:0] tc [6] = '{3'd0, 3'd0, 3'd6, 3'd5, 3'd1, 3'd0};
      logic [W-1:0] td [6] = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
      logic [W-1:0] te [6] = '{3'd0, 3'd4, 3'd3, 3'd0, 3'd0, 3'd0};
      logic         ts1 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [1:0]   ts2 [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
      logic [2:0]   top [6] = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHL};
      logic [W-1:0] eo  [6] = '{3'd2, 3'd3, 3'd5, 3'd5, 3'd2, 3'd6};
      logic         ec  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== eo[i-2] || bus.carry_out !== ec[i-2]) begin
               n_fail++;
               $display("FAIL op_row[%0d]: valid=%b out=%0d carry=%b, required 1 %0d %b",
                        i-2, bus.out_valid, bus.out, bus.carry_out, eo[i-2], ec[i-2]);
            end
         end
         if (i < 6) drive(1'b1, ta[i], tb[i], tc[i], td[i], te[i], ts1[i], ts2[i], top[i]);
         else       drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 2'd0, 3'd0);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(1'b1, 3'd1, 3'd1, '0, '0, '0, 1'b0, 2'd0, OP_ADD);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready_one_held: in_ready=%b, required 1", bus.in_ready);
      end
      drive(1'b1, 3'd1, 3'd2, '0, '0, '0, 1'b0, 2'd0, OP_ADD);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out !== 3'd2) begin
         n_fail++;
         $display("FAIL bp_full: in_ready=%b valid=%b out=%0d, required 0 1 2",
                  bus.in_ready, bus.out_valid, bus.out);
      end
      drive(1'b1, 3'd2, 3'd2, '0, '0, '0, 1'b0, 2'd0, OP_ADD);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out !== 3'd2 ||
          bus.carry_out !== 1'b0 || bus.acc !== 3'd2) begin
         n_fail++;
         $display("FAIL bp_hold: in_ready=%b valid=%b out=%0d carry=%b acc=%0d, required 0 1 2 0 2",
                  bus.in_ready, bus.out_valid, bus.out, bus.carry_out, bus.acc);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(negedge clk);
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 2'd0, 3'd0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== 3'd3) begin
         n_fail++;
         $display("FAIL bp_second: valid=%b out=%0d, required 1 3", bus.out_valid, bus.out);
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== 3'd4 || bus.acc !== 3'd4) begin
         n_fail++;
         $display("FAIL bp_third: valid=%b out=%0d acc=%0d, required 1 4 4", bus.out_valid, bus.out, bus.acc);
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_no_duplicate: out_valid=%b, required 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_in_flight();
      @(negedge clk);
      drive(1'b1, 3'd1, 3'd2, '0, '0, '0, 1'b0, 2'd0, OP_ADD);
      @(negedge clk);
      drive(1'b1, 3'd3, 3'd3, '0, '0, '0, 1'b0, 2'd0, OP_ADD);
      @(negedge clk);
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 2'd0, 3'd0);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.acc !== 3'd0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_flush: valid=%b acc=%0d in_ready=%b, required 0 0 1",
                  bus.out_valid, bus.acc, bus.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_stale[%0d]: out_valid=%b, required 0", i, bus.out_valid);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_add();
      test_sub_adc();
      test_back_to_back_acc();
      test_overflow();
      test_ops_and_muxes();
      test_backpressure();
      test_reset_in_flight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
